// File: rtl/uart_pkg.sv
// Shared UART subsystem definitions: default counter/prescaler widths,
// the channel-count ceiling, a channel-index type and the per-channel
// activity state encoding used by the activity monitor.
package uart_pkg;

  localparam int unsigned UART_CNT_W   = 32;
  localparam int unsigned UART_PRESC_W = 16;
  localparam int unsigned UART_MAX_CH  = 32;

  typedef logic [$clog2(UART_MAX_CH)-1:0] ch_idx_t;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

endpackage

// File: rtl/uart_act_mon_ch.sv
// One channel of the UART activity monitor: a retriggerable timeout
// down-counter, the active/idle state, registered edge pulses and the
// optional sticky timeout flag (macro UART_ACT_MON_STICKY_EN).
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   run_i            global enable AND channel enable; 0 holds reset state
//   tick_i           shared prescaler tick
//   monitor_i        activity strobe, retriggers the channel
//   preset_i         timeout in ticks
//   evt_clr_i        write-1-to-clear for the sticky flag
//   state_o          1 = channel active
//   active_o         1-clk pulse after state rises
//   inactive_o       1-clk pulse after state falls
//   timeout_flg_o    sticky timeout flag (0 when macro undefined)
module uart_act_mon_ch
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W = UART_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run_i,
  input  logic             tick_i,
  input  logic             monitor_i,
  input  logic [CNT_W-1:0] preset_i,
  input  logic             evt_clr_i,
  output logic             state_o,
  output logic             active_o,
  output logic             inactive_o,
  output logic             timeout_flg_o
);

  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             prev_q;
  logic             active_q;
  logic             inactive_q;

  // prev_q is cleared together with state_q so a reset or disable in the
  // middle of a timeout never produces an inactive pulse.
  always_ff @(posedge clk) begin
    if (!rstn || !run_i) begin
      state_q    <= CH_IDLE;
      cnt_q      <= preset_i;
      prev_q     <= 1'b0;
      active_q   <= 1'b0;
      inactive_q <= 1'b0;
    end else begin
      prev_q     <= (state_q == CH_ACTIVE);
      active_q   <= (state_q == CH_ACTIVE) && !prev_q;
      inactive_q <= (state_q == CH_IDLE) && prev_q;
      if (monitor_i) begin
        cnt_q   <= preset_i;
        state_q <= CH_ACTIVE;
      end else if (state_q == CH_IDLE) begin
        cnt_q <= preset_i;
      end else if (tick_i) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          state_q <= CH_IDLE;
        end
      end
    end
  end

  assign state_o    = (state_q == CH_ACTIVE);
  assign active_o   = active_q;
  assign inactive_o = inactive_q;

`ifdef UART_ACT_MON_STICKY_EN
  logic flg_q;

  // Set takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn || !run_i) begin
      flg_q <= 1'b0;
    end else begin
      flg_q <= inactive_q | (flg_q & ~evt_clr_i);
    end
  end

  assign timeout_flg_o = flg_q;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = evt_clr_i;
  assign timeout_flg_o  = 1'b0;
`endif

endmodule

// File: rtl/uart_activity_monitor.sv
// Multi-channel UART line-activity watchdog. A shared prescaler produces
// the count tick; each channel retriggers on activity and drops after its
// programmable idle timeout. Optional sticky flags and irq are enabled by
// macro UART_ACT_MON_STICKY_EN (port list identical in both builds).
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   en            global enable (0 = everything held in reset state)
//   ch_en         per-channel enable
//   presc_div     tick period minus 1
//   preset        per-channel timeout, channel i at [i*CNT_W +: CNT_W]
//   monitor_in    per-channel activity strobe
//   state         per-channel active state
//   active        1-clk pulse on state rise
//   inactive      1-clk pulse on state fall
//   any_active    combinational OR of state
//   evt_clr       write-1-to-clear for timeout_flg
//   timeout_flg   sticky timeout flags
//   irq           registered OR of timeout_flg
module uart_activity_monitor
  import uart_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = UART_CNT_W,
  parameter int unsigned PRESC_W = UART_PRESC_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [PRESC_W-1:0]      presc_div,
  input  logic [NUM_CH*CNT_W-1:0] preset,
  input  logic [NUM_CH-1:0]       monitor_in,
  output logic [NUM_CH-1:0]       state,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       inactive,
  output logic                    any_active,
  input  logic [NUM_CH-1:0]       evt_clr,
  output logic [NUM_CH-1:0]       timeout_flg,
  output logic                    irq
);

  logic [PRESC_W-1:0] presc_q;
  logic               tick;

  // Only an exact match ticks; a divisor lowered below the current count
  // lets the counter run on to its natural roll-over.
  assign tick = (presc_q == presc_div);

  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_act_mon_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk           (clk),
      .rstn          (rstn),
      .run_i         (en & ch_en[i]),
      .tick_i        (tick),
      .monitor_i     (monitor_in[i]),
      .preset_i      (preset[i*CNT_W +: CNT_W]),
      .evt_clr_i     (evt_clr[i]),
      .state_o       (state[i]),
      .active_o      (active[i]),
      .inactive_o    (inactive[i]),
      .timeout_flg_o (timeout_flg[i])
    );
  end

  assign any_active = |state;

`ifdef UART_ACT_MON_STICKY_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |timeout_flg;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_activity_monitor.sv
// Directed self-checking bench for uart_activity_monitor. Works in both
// builds; expectations for sticky flags and irq follow
// UART_ACT_MON_STICKY_EN.
module tb_uart_activity_monitor;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned PRESC_W = 16;

`ifdef UART_ACT_MON_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    en;
  logic [NUM_CH-1:0]       ch_en;
  logic [PRESC_W-1:0]      presc_div;
  logic [NUM_CH*CNT_W-1:0] preset;
  logic [NUM_CH-1:0]       monitor_in;
  logic [NUM_CH-1:0]       state;
  logic [NUM_CH-1:0]       active;
  logic [NUM_CH-1:0]       inactive;
  logic                    any_active;
  logic [NUM_CH-1:0]       evt_clr;
  logic [NUM_CH-1:0]       timeout_flg;
  logic                    irq;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  uart_activity_monitor #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .ch_en      (ch_en),
    .presc_div  (presc_div),
    .preset     (preset),
    .monitor_in (monitor_in),
    .state      (state),
    .active     (active),
    .inactive   (inactive),
    .any_active (any_active),
    .evt_clr    (evt_clr),
    .timeout_flg(timeout_flg),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance n clocks; inputs and samples sit 1 time unit after the edge.
  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_preset(input int unsigned ch, input logic [CNT_W-1:0] v);
    preset[ch*CNT_W +: CNT_W] = v;
  endtask

  initial begin
    int unsigned bad;
    bit          seen;

    rstn       = 1'b0;
    en         = 1'b0;
    ch_en      = '1;
    presc_div  = 16'd3;
    preset     = '0;
    monitor_in = '0;
    evt_clr    = '0;
    step(2);

    // Reset state
    check("rst_state", state, 0);
    check("rst_active", active, 0);
    check("rst_inactive", inactive, 0);
    check("rst_any", any_active, 0);
    check("rst_flg", timeout_flg, 0);
    check("rst_irq", irq, 0);

    // 1. Single strobe with presc_div=3, preset=2 (prescaler phase zeroed by en=0)
    rstn = 1'b1;
    set_preset(0, 32'd2);
    step(1);
    en            = 1'b1;
    monitor_in[0] = 1'b1;
    step(1);                                   // E1
    check("t1_state_rise", state[0], 1);
    check("t1_active_early", active[0], 0);
    check("t1_any", any_active, 1);
    monitor_in[0] = 1'b0;
    step(1);                                   // E2
    check("t1_active_pulse", active[0], 1);
    step(1);                                   // E3
    check("t1_active_end", active[0], 0);
    step(8);                                   // E11
    check("t1_state_held", state[0], 1);
    step(1);                                   // E12: third tick with cnt==0
    check("t1_state_drop", state[0], 0);
    check("t1_inactive_early", inactive[0], 0);
    step(1);                                   // E13
    check("t1_inactive_pulse", inactive[0], 1);
    check("t1_irq_before_flag", irq, 0);
    step(1);                                   // E14
    check("t1_inactive_end", inactive[0], 0);
    check("t1_flag", timeout_flg[0], STICKY);
    check("t1_irq_lag", irq, 0);
    step(1);                                   // E15
    check("t1_irq", irq, STICKY);

    // 6a. Plain clear
    evt_clr[0] = 1'b1;
    step(1);
    evt_clr[0] = 1'b0;
    check("t6_clr_flag", timeout_flg[0], 0);
    check("t6_clr_irq_lag", irq, STICKY);
    step(1);
    check("t6_clr_irq", irq, 0);

    // 6b. Clear coinciding with a new inactive pulse: set wins
    monitor_in[0] = 1'b1;
    step(1);
    monitor_in[0] = 1'b0;
    seen = 1'b0;
    for (int unsigned k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (inactive[0]) seen = 1'b1;
    end
    check("t6_timeout_seen", seen, 1);
    evt_clr[0] = 1'b1;
    step(1);
    evt_clr[0] = 1'b0;
    check("t6_set_wins", timeout_flg[0], STICKY);
    step(1);
    check("t6_irq", irq, STICKY);
    evt_clr = '1;
    step(1);
    evt_clr = '0;

    // Switch to presc_div=0 with the prescaler restarted from 0
    en        = 1'b0;
    presc_div = 16'd0;
    step(1);
    check("dis_flags", timeout_flg, 0);
    en = 1'b1;

    // 2. Retrigger ch1 every 8 clks, preset=10
    set_preset(1, 32'd10);
    bad = 0;
    for (int unsigned p = 0; p < 5; p++) begin
      monitor_in[1] = 1'b1;
      step(1);
      monitor_in[1] = 1'b0;
      for (int unsigned k = 0; k < 7; k++) begin
        step(1);
        if (state[1] !== 1'b1 || inactive[1] !== 1'b0) bad++;
      end
    end
    check("t2_hold", bad, 0);
    monitor_in[1] = 1'b1;
    step(1);
    monitor_in[1] = 1'b0;
    step(10);
    check("t2_last_tick_held", state[1], 1);
    step(1);
    check("t2_drop_11_ticks", state[1], 0);
    step(1);
    check("t2_inactive", inactive[1], 1);

    // 3. Strobe in the tick cycle where cnt==0 (ch2, preset=1)
    set_preset(2, 32'd1);
    monitor_in[2] = 1'b1;
    step(1);                                   // S: cnt=1
    monitor_in[2] = 1'b0;
    step(1);                                   // S+1: cnt=0
    monitor_in[2] = 1'b1;
    step(1);                                   // S+2: retrigger wins
    monitor_in[2] = 1'b0;
    check("t3_state_kept", state[2], 1);
    step(1);                                   // S+3: cnt reloaded to 1 -> 0
    check("t3_no_inactive", inactive[2], 0);
    check("t3_reloaded", state[2], 1);
    step(1);                                   // S+4
    check("t3_drop", state[2], 0);
    step(1);
    check("t3_inactive", inactive[2], 1);

    // 4. preset=0 drops at the first tick; preset=all-ones never wraps
    set_preset(0, 32'd0);
    monitor_in[0] = 1'b1;
    step(1);
    monitor_in[0] = 1'b0;
    check("t4_p0_rise", state[0], 1);
    step(1);
    check("t4_p0_drop", state[0], 0);
    set_preset(0, 32'hFFFF_FFFF);
    monitor_in[0] = 1'b1;
    step(1);
    monitor_in[0] = 1'b0;
    bad = 0;
    for (int unsigned k = 0; k < 60; k++) begin
      step(1);
      if (state[0] !== 1'b1) bad++;
    end
    check("t4_max_no_wrap", bad, 0);

    // 5a. rstn pulse mid-count
    set_preset(3, 32'd20);
    monitor_in[3] = 1'b1;
    step(1);
    monitor_in[3] = 1'b0;
    step(5);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    check("t5_rst_state", state, 0);
    check("t5_rst_any", any_active, 0);
    check("t5_rst_pulses", {active, inactive}, 0);
    bad = 0;
    for (int unsigned k = 0; k < 2; k++) begin
      step(1);
      if (inactive !== '0) bad++;
    end
    check("t5_rst_no_inactive", bad, 0);
    monitor_in[3] = 1'b1;
    step(1);
    monitor_in[3] = 1'b0;
    step(20);
    check("t5_reload_held", state[3], 1);
    step(1);
    check("t5_reload_drop", state[3], 0);

    // 5b. en=0 mid-count
    set_preset(0, 32'd50);
    monitor_in = 4'b1001;
    step(1);
    monitor_in = '0;
    step(5);
    en = 1'b0;
    step(1);
    en = 1'b1;
    check("t5_en_state", state, 0);
    check("t5_en_pulses", {active, inactive}, 0);
    bad = 0;
    for (int unsigned k = 0; k < 2; k++) begin
      step(1);
      if (inactive !== '0) bad++;
    end
    check("t5_en_no_inactive", bad, 0);

    // 5c. ch_en[3]=0 mid-count, ch0 unaffected
    monitor_in = 4'b1001;
    step(1);
    monitor_in = '0;
    step(3);
    ch_en[3] = 1'b0;
    step(1);
    check("t5_chen_state", state, 4'b0001);
    check("t5_chen_pulses", {active, inactive}, 0);
    step(1);
    check("t5_chen_no_inactive", inactive, 0);
    ch_en[3] = 1'b1;
    monitor_in[3] = 1'b1;
    step(1);
    monitor_in[3] = 1'b0;
    step(20);
    check("t5_chen_reload_held", state[3], 1);
    step(1);
    check("t5_chen_reload_drop", state[3], 0);
    check("t5_ch0_still_on", state[0], 1);
    check("irq_final", irq, STICKY & (|timeout_flg));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
